// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU memory stage and a DMA engine.
// CPU wins by default; a saturating wait counter forces DMA through, and DMA bursts are capped at BURST_MAX beats.
module data_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned BURST_MAX    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   input  logic        dma_last,
   output logic        dma_gnt,
   output logic [31:0] dma_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   typedef enum logic {CPU_OWN = 1'b0, DMA_OWN = 1'b1} state_t;

   localparam logic [3:0] STARVE_L = 4'(STARVE_LIMIT);
   localparam logic [3:0] BURST_L  = 4'(BURST_MAX);

   state_t     state;
   logic [3:0] wait_cnt;
   logic [3:0] beat_cnt;
   logic [3:0] beat_next;
   logic       cpu_req;
   logic       force_dma;
   logic       serve_cpu;
   logic       serve_dma;

   assign cpu_req   = cpu_read | cpu_write;
   assign force_dma = dma_req & (wait_cnt == STARVE_L);
   assign beat_next = beat_cnt + 4'd1;

   // Reset masks every grant so nothing reaches the memory in the reset cycle.
   always_comb begin
      serve_cpu = 1'b0;
      serve_dma = 1'b0;
      if (!reset) begin
         if (state == CPU_OWN) begin
            serve_cpu = cpu_req & ~force_dma;
            serve_dma = dma_req & ~serve_cpu;
         end else begin
            serve_dma = dma_req;
         end
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      if (serve_cpu) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_write = cpu_write;
         mem_read  = cpu_read & ~cpu_write;
      end else if (serve_dma) begin
         mem_addr  = dma_addr;
         mem_wdata = dma_wdata;
         mem_write = dma_we;
         mem_read  = ~dma_we;
      end
   end

   assign dma_gnt   = serve_dma;
   assign cpu_stall = ~reset & cpu_req & ~serve_cpu;
   assign cpu_rdata = mem_rdata;
   assign dma_rdata = mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= CPU_OWN;
         wait_cnt <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            CPU_OWN: begin
               if (serve_cpu && dma_req)
                  wait_cnt <= (wait_cnt >= STARVE_L) ? STARVE_L : wait_cnt + 4'd1;
               else
                  wait_cnt <= '0;
               if (serve_dma && !dma_last && (BURST_MAX > 1)) begin
                  state    <= DMA_OWN;
                  beat_cnt <= 4'd1;
               end
            end
            DMA_OWN: begin
               // Clearing here lets a stalled CPU win the first cycle after the burst.
               wait_cnt <= '0;
               if (!dma_req || dma_last || (beat_next == BURST_L)) begin
                  state    <= CPU_OWN;
                  beat_cnt <= '0;
               end else begin
                  beat_cnt <= beat_next;
               end
            end
            default: begin
               state    <= CPU_OWN;
               beat_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, hand sequences, and
// randomized traffic against a cycle-level reference model of the arbitration rules.
module tb_data_mem_arbiter;
   localparam int LIM  = 4;
   localparam int BMAX = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_read, cpu_write, cpu_stall;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        dma_req, dma_we, dma_last, dma_gnt;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write;
   logic [31:0] tbmem [0:255];

   int n_cmp = 0;
   int n_err = 0;
   int refused = 0;

   // reference model state
   bit m_burst;
   int m_wait, m_beats;
   bit e_gnt, e_stall, e_rd, e_wr, e_cpu;
   logic [31:0] e_addr, e_wdata;

   typedef struct {
      bit cr, cw; logic [31:0] ca;
      bit dr, dwe, dl; logic [31:0] da;
      bit eg, es, ew, er;
   } vec_t;
   vec_t vt[$];

   data_mem_arbiter #(.STARVE_LIMIT(LIM), .BURST_MAX(BMAX)) dut (
      .clk(clk), .reset(reset),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_last(dma_last), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   assign mem_rdata = tbmem[mem_addr[9:2]];
   always @(posedge clk) if (mem_write) tbmem[mem_addr[9:2]] <= mem_wdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic void model_eval();
      bit creq;
      creq = cpu_read | cpu_write;
      e_gnt = 0; e_stall = 0; e_rd = 0; e_wr = 0; e_cpu = 0; e_addr = 0; e_wdata = 0;
      if (reset) return;
      if (!m_burst && creq && !(dma_req && m_wait == LIM)) e_cpu = 1;
      else e_gnt = dma_req;
      e_stall = creq && !e_cpu;
      if (e_cpu) begin
         e_addr = cpu_addr; e_wdata = cpu_wdata; e_wr = cpu_write; e_rd = cpu_read && !cpu_write;
      end else if (e_gnt) begin
         e_addr = dma_addr; e_wdata = dma_wdata; e_wr = dma_we; e_rd = !dma_we;
      end
   endfunction

   function automatic void model_update();
      if (reset) begin
         m_burst = 0; m_wait = 0; m_beats = 0;
         return;
      end
      if (m_burst) begin
         m_wait = 0;
         m_beats = dma_req ? m_beats + 1 : 0;
         if (!dma_req || dma_last || m_beats == BMAX) begin
            m_burst = 0; m_beats = 0;
         end
      end else if (e_cpu) begin
         m_wait = dma_req ? ((m_wait < LIM) ? m_wait + 1 : LIM) : 0;
      end else begin
         m_wait = 0;
         if (e_gnt && !dma_last && BMAX > 1) begin
            m_burst = 1; m_beats = 1;
         end
      end
   endfunction

   task automatic sample(input string tag);
      @(negedge clk);
      model_eval();
      chk({tag, ".gnt"},   32'(dma_gnt),   32'(e_gnt));
      chk({tag, ".stall"}, 32'(cpu_stall), 32'(e_stall));
      chk({tag, ".rd"},    32'(mem_read),  32'(e_rd));
      chk({tag, ".wr"},    32'(mem_write), 32'(e_wr));
      chk({tag, ".addr"},  mem_addr,       e_addr);
      chk({tag, ".wdata"}, mem_wdata,      e_wdata);
      if (reset || !dma_req) refused = 0;
      else if (dma_gnt) begin
         chk({tag, ".starve_bound"}, 32'(refused <= LIM), 32'd1);
         refused = 0;
      end else refused++;
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input bit cr, cw, input logic [31:0] ca,
                        input bit dr, dwe, dl, input logic [31:0] da);
      cpu_read = cr; cpu_write = cw; cpu_addr = ca; cpu_wdata = 32'hC0DE0000 | ca;
      dma_req = dr; dma_we = dwe; dma_last = dl; dma_addr = da; dma_wdata = da ^ 32'hA5A50000;
   endtask

   function automatic void add(input bit cr, cw, input logic [31:0] ca,
                               input bit dr, dwe, dl, input logic [31:0] da,
                               input bit eg, es, ew, er);
      vec_t v;
      v.cr = cr; v.cw = cw; v.ca = ca; v.dr = dr; v.dwe = dwe; v.dl = dl; v.da = da;
      v.eg = eg; v.es = es; v.ew = ew; v.er = er;
      vt.push_back(v);
   endfunction

   initial begin
      for (int i = 0; i < 256; i++) tbmem[i] = '0;
      m_burst = 0; m_wait = 0; m_beats = 0;

      // starvation: CPU reads every cycle, DMA single-beat write pending
      for (int i = 0; i < LIM; i++) add(1, 0, 32'h200, 1, 1, 1, 32'h300, 0, 0, 0, 1);
      add(1, 0, 32'h200, 1, 1, 1, 32'h300, 1, 1, 1, 0);
      add(1, 0, 32'h200, 1, 1, 1, 32'h300, 0, 0, 0, 1);
      add(0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 0);
      // three-beat write burst, CPU read arrives in beat 2
      add(0, 0, 32'h0,   1, 1, 0, 32'h100, 1, 0, 1, 0);
      add(1, 0, 32'h100, 1, 1, 0, 32'h104, 1, 1, 1, 0);
      add(1, 0, 32'h100, 1, 1, 1, 32'h108, 1, 1, 1, 0);
      add(1, 0, 32'h100, 0, 0, 0, 32'h0,   0, 0, 0, 1);
      add(0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 0);
      // burst cap: 12 read beats, never last
      add(0, 0, 32'h0,   1, 0, 0, 32'h400, 1, 0, 0, 1);
      for (int i = 0; i < BMAX - 1; i++) add(1, 0, 32'h104, 1, 0, 0, 32'h400, 1, 1, 0, 1);
      add(1, 0, 32'h104, 1, 0, 0, 32'h400, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) add(0, 0, 32'h0, 1, 0, 0, 32'h400, 1, 0, 0, 1);
      add(0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 0);
      // early release after beat 2, then read+write CPU request acts as a write
      add(0, 0, 32'h0,   1, 1, 0, 32'h500, 1, 0, 1, 0);
      add(0, 0, 32'h0,   1, 1, 0, 32'h504, 1, 0, 1, 0);
      add(1, 0, 32'h500, 0, 1, 0, 32'h508, 0, 1, 0, 0);
      add(1, 0, 32'h500, 0, 0, 0, 32'h0,   0, 0, 0, 1);
      add(1, 1, 32'h600, 0, 0, 0, 32'h0,   0, 0, 1, 0);
      add(0, 0, 32'h0,   0, 0, 0, 32'h0,   0, 0, 0, 0);

      // reset state
      reset = 1;
      drive(1, 1, 32'h44, 1, 1, 0, 32'h88);
      #1;
      sample("reset0");
      advance();
      sample("reset1");
      advance();
      chk("reset.wait_cnt", 32'(dut.wait_cnt), 0);
      chk("reset.beat_cnt", 32'(dut.beat_cnt), 0);
      reset = 0;

      // CPU only: store then load back
      drive(0, 1, 32'h10010000, 0, 0, 0, 32'h0);
      cpu_wdata = 32'hDEADBEEF;
      sample("cpu_wr");
      chk("cpu_wr.mem_write", 32'(mem_write), 1);
      chk("cpu_wr.stall", 32'(cpu_stall), 0);
      advance();
      drive(1, 0, 32'h10010000, 0, 0, 0, 32'h0);
      sample("cpu_rd");
      chk("cpu_rd.mem_write", 32'(mem_write), 0);
      chk("cpu_rd.rdata", cpu_rdata, 32'hDEADBEEF);
      chk("cpu_rd.stall", 32'(cpu_stall), 0);
      advance();

      foreach (vt[i]) begin
         string t;
         t = $sformatf("vec%0d", i);
         drive(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].dr, vt[i].dwe, vt[i].dl, vt[i].da);
         sample(t);
         chk({t, ".tab_gnt"},   32'(dma_gnt),   32'(vt[i].eg));
         chk({t, ".tab_stall"}, 32'(cpu_stall), 32'(vt[i].es));
         chk({t, ".tab_wr"},    32'(mem_write), 32'(vt[i].ew));
         chk({t, ".tab_rd"},    32'(mem_read),  32'(vt[i].er));
         advance();
      end

      // reset asserted during beat 3 of a write burst
      for (int b = 0; b < 2; b++) begin
         drive(0, 0, 32'h0, 1, 1, 0, 32'h700 + 32'(b * 4));
         sample("rst_burst_beat");
         advance();
      end
      reset = 1;
      drive(0, 0, 32'h0, 1, 1, 0, 32'h708);
      sample("rst_mid");
      chk("rst_mid.wr", 32'(mem_write), 0);
      chk("rst_mid.rd", 32'(mem_read), 0);
      chk("rst_mid.gnt", 32'(dma_gnt), 0);
      advance();
      reset = 0;
      chk("rst_mid.wait_cnt", 32'(dut.wait_cnt), 0);
      chk("rst_mid.beat_cnt", 32'(dut.beat_cnt), 0);
      drive(1, 0, 32'h20, 1, 1, 1, 32'h708);
      sample("rst_after");
      chk("rst_after.cpu_served", 32'(cpu_stall), 0);
      advance();

      // randomized traffic; requesters hold their fields until served
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (!e_stall) begin
            int k;
            k = $urandom_range(0, 4);
            cpu_read = (k == 1) || (k == 3);
            cpu_write = (k == 2) || (k == 3);
            cpu_addr = 32'($urandom_range(0, 255)) << 2;
            cpu_wdata = $urandom;
         end
         if (!(dma_req && !e_gnt)) begin
            dma_req = ($urandom_range(0, 2) != 0);
            dma_we = $urandom_range(0, 1) == 1;
            dma_last = ($urandom_range(0, 5) == 0);
            dma_addr = 32'($urandom_range(0, 255)) << 2;
            dma_wdata = $urandom;
         end
         sample("rand");
         advance();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
